// File: rtl/dir_pkg.sv
// ---------------------------------------------------------------------------
// dir_pkg
//   Shared definitions for the directory controller slice: processor count,
//   directory block states and the coherence message encodings carried on
//   the interconnect message port.
// ---------------------------------------------------------------------------
package dir_pkg;

   localparam int NPROC = 8;

   typedef enum logic [1:0] {
      UNCACHED  = 2'b00,
      EXCLUSIVE = 2'b01,
      SHARED    = 2'b10
   } dir_state_e;

   typedef enum logic [1:0] {
      FETCH            = 2'b00,
      INVALIDATE       = 2'b01,
      FETCH_INVALIDATE = 2'b10,
      DATA_VALUE_REPLY = 2'b11
   } msg_type_e;

endpackage

// File: rtl/dir_msg_dispatch_if.sv
// ---------------------------------------------------------------------------
// dir_msg_dispatch_if
//   Point-to-point message port toward the interconnect (valid/ready).
//   master : the dispatcher (drives msg_valid, msg_type, msg_dest, msg_addr)
//   slave  : the interconnect (drives msg_ready)
// ---------------------------------------------------------------------------
interface dir_msg_dispatch_if #(
   parameter int NPROC  = dir_pkg::NPROC,
   parameter int ADDR_W = 8
);

   logic               msg_valid;
   logic               msg_ready;
   dir_pkg::msg_type_e msg_type;
   logic [NPROC-1:0]   msg_dest;   // one-hot destination processor
   logic [ADDR_W-1:0]  msg_addr;

   modport master (
      output msg_valid, msg_type, msg_dest, msg_addr,
      input  msg_ready
   );

   modport slave (
      input  msg_valid, msg_type, msg_dest, msg_addr,
      output msg_ready
   );

endinterface

// File: rtl/dir_msg_dispatch_lowest_onehot.sv
// ---------------------------------------------------------------------------
// lowest_onehot
//   Priority encoder: returns the lowest set bit of vec as a one-hot vector
//   (all zeros when vec is zero).
//   vec    : input bit vector
//   onehot : lowest set bit of vec, one-hot
// ---------------------------------------------------------------------------
module lowest_onehot #(
   parameter int NPROC = dir_pkg::NPROC
) (
   input  logic [NPROC-1:0] vec,
   output logic [NPROC-1:0] onehot
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      onehot = '0;
      for (int i = NPROC - 1; i >= 0; i--) begin
         if (vec[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dir_msg_dispatch.sv
// ---------------------------------------------------------------------------
// dir_msg_dispatch
//   Takes one resolved directory action (fetch / invalidate / data reply) and
//   serialises it into point-to-point messages, at most one per cycle, in the
//   order FETCH, INVALIDATEs (ascending processor index), DATA_VALUE_REPLY.
//   done pulses the cycle after the last message handshakes.
//
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   req_valid / req_ready  : action handshake from the directory
//   send_fetch, send_invalidate, send_data_value_reply : action flags
//   requesting_processor   : one-hot requester
//   bit_vector             : sharers/owner before the transition
//   block_address          : block concerned
//   msg                    : message port (master side)
//   done                   : completion pulse
// ---------------------------------------------------------------------------
module dir_msg_dispatch #(
   parameter int NPROC  = dir_pkg::NPROC,
   parameter int ADDR_W = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                send_fetch,
   input  logic                send_invalidate,
   input  logic                send_data_value_reply,
   input  logic [NPROC-1:0]    requesting_processor,
   input  logic [NPROC-1:0]    bit_vector,
   input  logic [ADDR_W-1:0]   block_address,
   dir_msg_dispatch_if.master  msg,
   output logic                done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_INVAL = 2'b10,
      ST_REPLY = 2'b11
   } state_e;

   state_e              state_q, state_d;
   logic                inval_q, reply_q;
   logic [NPROC-1:0]    req_q, bv_q;
   logic [NPROC-1:0]    inv_mask_q, inv_mask_d;
   logic [ADDR_W-1:0]   addr_q;
   logic                done_d;
   logic                accept;
   logic                reply_ok;
   logic [NPROC-1:0]    owner;
   logic [NPROC-1:0]    next_inv;

   // Owner is the lowest sharer of the latched vector; invalidates walk the
   // remaining mask from the lowest bit upward.
   lowest_onehot #(.NPROC(NPROC)) u_owner_pick (.vec(bv_q),       .onehot(owner));
   lowest_onehot #(.NPROC(NPROC)) u_inval_pick (.vec(inv_mask_q), .onehot(next_inv));

   assign req_ready = (state_q == ST_IDLE) && !reset;
   assign accept    = req_valid && req_ready;
   // A reply to a null requester is skipped rather than sent nowhere.
   assign reply_ok  = reply_q && (|req_q);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         inval_q    <= 1'b0;
         reply_q    <= 1'b0;
         req_q      <= '0;
         bv_q       <= '0;
         addr_q     <= '0;
         inv_mask_q <= '0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_d;
         inv_mask_q <= inv_mask_d;
         done       <= done_d;
         if (accept) begin
            inval_q <= send_invalidate;
            reply_q <= send_data_value_reply;
            req_q   <= requesting_processor;
            bv_q    <= bit_vector;
            addr_q  <= block_address;
         end
      end
   end

   // Message fields are decoded from registered state only, so they stay
   // stable for as long as the interconnect stalls.
   // NOTE: every output of this block gets a default first so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d        = state_q;
      inv_mask_d     = inv_mask_q;
      done_d         = 1'b0;
      msg.msg_valid  = 1'b0;
      msg.msg_type   = dir_pkg::FETCH;
      msg.msg_dest   = '0;
      msg.msg_addr   = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               inv_mask_d = bit_vector & ~requesting_processor;
               if (send_fetch && (|bit_vector))
                  state_d = ST_FETCH;
               else if (send_invalidate && (|inv_mask_d))
                  state_d = ST_INVAL;
               else if (send_data_value_reply && (|requesting_processor))
                  state_d = ST_REPLY;
               else
                  done_d = 1'b1;
            end
         end

         ST_FETCH: begin
            msg.msg_valid = 1'b1;
            msg.msg_type  = inval_q ? dir_pkg::FETCH_INVALIDATE : dir_pkg::FETCH;
            msg.msg_dest  = owner;
            msg.msg_addr  = addr_q;
            if (msg.msg_ready) begin
               // The owner is invalidated by the combined fetch.
               inv_mask_d = inv_mask_q & ~owner;
               if (inval_q && (|inv_mask_d)) state_d = ST_INVAL;
               else if (reply_ok)            state_d = ST_REPLY;
               else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         ST_INVAL: begin
            msg.msg_valid = 1'b1;
            msg.msg_type  = dir_pkg::INVALIDATE;
            msg.msg_dest  = next_inv;
            msg.msg_addr  = addr_q;
            if (msg.msg_ready) begin
               inv_mask_d = inv_mask_q & ~next_inv;
               if (|inv_mask_d)   state_d = ST_INVAL;
               else if (reply_ok) state_d = ST_REPLY;
               else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         ST_REPLY: begin
            msg.msg_valid = 1'b1;
            msg.msg_type  = dir_pkg::DATA_VALUE_REPLY;
            msg.msg_dest  = req_q;
            msg.msg_addr  = addr_q;
            if (msg.msg_ready) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   // A multi-hot requester is an upstream bug; zero is legal (no reply).
   a_req_onehot: assert property (@(posedge clock) disable iff (reset)
      (req_valid && req_ready) |-> $onehot0(requesting_processor));

endmodule

// File: tb/tb_dir_msg_dispatch.sv
// ---------------------------------------------------------------------------
// tb_dir_msg_dispatch
//   Directed bench for dir_msg_dispatch. Each observation packs
//   {msg_valid, msg_type, msg_dest, msg_addr, done, req_ready} and is
//   compared against a hand-computed vector one time unit after the edge.
// ---------------------------------------------------------------------------
module tb_dir_msg_dispatch;

   logic       clock;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic       send_fetch;
   logic       send_invalidate;
   logic       send_data_value_reply;
   logic [7:0] requesting_processor;
   logic [7:0] bit_vector;
   logic [7:0] block_address;
   logic       done;

   int n_cmp = 0;
   int n_bad = 0;

   dir_msg_dispatch_if #(.NPROC(8), .ADDR_W(8)) mif ();

   dir_msg_dispatch #(.NPROC(8), .ADDR_W(8)) dut (
      .clock                 (clock),
      .reset                 (reset),
      .req_valid             (req_valid),
      .req_ready             (req_ready),
      .send_fetch            (send_fetch),
      .send_invalidate       (send_invalidate),
      .send_data_value_reply (send_data_value_reply),
      .requesting_processor  (requesting_processor),
      .bit_vector            (bit_vector),
      .block_address         (block_address),
      .msg                   (mif),
      .done                  (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [20:0] obs;
   assign obs = {mif.msg_valid, mif.msg_type, mif.msg_dest, mif.msg_addr, done, req_ready};

   function automatic logic [20:0] ev(input logic v, input logic [1:0] t,
                                      input logic [7:0] d, input logic [7:0] a,
                                      input logic dn, input logic rdy);
      return {v, t, d, a, dn, rdy};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Presents one action for a single cycle; returns in cycle N+1.
   task automatic issue(input logic f, input logic i, input logic r,
                        input logic [7:0] rq, input logic [7:0] bv, input logic [7:0] ad);
      req_valid             = 1'b1;
      send_fetch            = f;
      send_invalidate       = i;
      send_data_value_reply = r;
      requesting_processor  = rq;
      bit_vector            = bv;
      block_address         = ad;
      step();
      req_valid             = 1'b0;
      send_fetch            = 1'b0;
      send_invalidate       = 1'b0;
      send_data_value_reply = 1'b0;
   endtask

   task automatic test_reset();
      logic [20:0] want;
      reset = 1'b1;
      step();
      want = ev(0, 2'b00, 8'h00, 8'h00, 0, 0);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL reset_hold: got %h want %h", obs, want); end
      reset = 1'b0;
      step();
      want = ev(0, 2'b00, 8'h00, 8'h00, 0, 1);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL reset_release: got %h want %h", obs, want); end
   endtask

   task automatic test_shared_write_miss();
      logic [20:0] want;
      mif.msg_ready = 1'b1;
      issue(0, 1, 1, 8'b0000_0100, 8'b0010_0110, 8'hA5);
      want = ev(1, 2'b01, 8'b0000_0010, 8'hA5, 0, 0);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL swm_inv0: got %h want %h", obs, want); end
      step();
      want = ev(1, 2'b01, 8'b0010_0000, 8'hA5, 0, 0);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL swm_inv1: got %h want %h", obs, want); end
      step();
      want = ev(1, 2'b11, 8'b0000_0100, 8'hA5, 0, 0);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL swm_reply: got %h want %h", obs, want); end
      step();
      want = ev(0, 2'b00, 8'h00, 8'h00, 1, 1);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL swm_done: got %h want %h", obs, want); end
      step();
      want = ev(0, 2'b00, 8'h00, 8'h00, 0, 1);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL swm_done_once: got %h want %h", obs, want); end
   endtask

   task automatic test_exclusive_write_miss();
      logic [20:0] want;
      mif.msg_ready = 1'b1;
      issue(1, 1, 1, 8'b0000_0001, 8'b1000_0000, 8'h3C);
      want = ev(1, 2'b10, 8'b1000_0000, 8'h3C, 0, 0);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL ewm_fetch_inv: got %h want %h", obs, want); end
      step();
      want = ev(1, 2'b11, 8'b0000_0001, 8'h3C, 0, 0);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL ewm_reply: got %h want %h", obs, want); end
      step();
      want = ev(0, 2'b00, 8'h00, 8'h00, 1, 1);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL ewm_done: got %h want %h", obs, want); end
      step();
   endtask

   task automatic test_fetch_only();
      logic [20:0] want;
      mif.msg_ready = 1'b1;
      issue(1, 0, 0, 8'b0000_0001, 8'b0001_1000, 8'h11);
      want = ev(1, 2'b00, 8'b0000_1000, 8'h11, 0, 0);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL fonly_fetch: got %h want %h", obs, want); end
      step();
      want = ev(0, 2'b00, 8'h00, 8'h00, 1, 1);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL fonly_done: got %h want %h", obs, want); end
      step();
   endtask

   task automatic test_backpressure();
      logic [20:0] want;
      logic [1:0]  tt [3] = '{2'b01, 2'b01, 2'b11};
      logic [7:0]  dd [3] = '{8'b0000_0010, 8'b0010_0000, 8'b0000_0100};
      int          nx = 0;
      mif.msg_ready = 1'b0;
      issue(0, 1, 1, 8'b0000_0100, 8'b0010_0110, 8'hC3);
      for (int k = 0; k < 3; k++) begin
         for (int s = 0; s < 3; s++) begin
            mif.msg_ready = (s == 2);
            want = ev(1, tt[k], dd[k], 8'hC3, 0, 0);
            n_cmp++;
            if (obs !== want) begin
               n_bad++;
               $display("FAIL bp_msg%0d_cyc%0d: got %h want %h", k, s, obs, want);
            end
            if (mif.msg_valid && mif.msg_ready) nx++;
            step();
         end
      end
      mif.msg_ready = 1'b1;
      want = ev(0, 2'b00, 8'h00, 8'h00, 1, 1);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL bp_done: got %h want %h", obs, want); end
      n_cmp++;
      if (nx !== 3) begin n_bad++; $display("FAIL bp_transfers: got %0d want 3", nx); end
      step();
   endtask

   task automatic test_no_flags();
      logic [20:0] want;
      issue(0, 0, 0, 8'b0000_0010, 8'b0000_0110, 8'h42);
      want = ev(0, 2'b00, 8'h00, 8'h00, 1, 1);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL noflag_done: got %h want %h", obs, want); end
      step();
      want = ev(0, 2'b00, 8'h00, 8'h00, 0, 1);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL noflag_after: got %h want %h", obs, want); end
   endtask

   task automatic test_reset_mid();
      logic [20:0] want;
      mif.msg_ready = 1'b1;
      issue(0, 1, 1, 8'b0000_0100, 8'b0010_0110, 8'h77);
      step();
      mif.msg_ready = 1'b0;
      want = ev(1, 2'b01, 8'b0010_0000, 8'h77, 0, 0);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL rmid_stall: got %h want %h", obs, want); end
      step();
      reset = 1'b1;
      step();
      want = ev(0, 2'b00, 8'h00, 8'h00, 0, 0);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL rmid_in_reset: got %h want %h", obs, want); end
      reset = 1'b0;
      step();
      want = ev(0, 2'b00, 8'h00, 8'h00, 0, 1);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL rmid_release: got %h want %h", obs, want); end
      step();
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL rmid_no_done: got %h want %h", obs, want); end
      mif.msg_ready = 1'b1;
   endtask

   task automatic test_requester_sharer();
      logic [20:0] want;
      mif.msg_ready = 1'b1;
      issue(0, 1, 1, 8'b0000_0010, 8'b0000_0111, 8'h5A);
      want = ev(1, 2'b01, 8'b0000_0001, 8'h5A, 0, 0);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL rs_inv0: got %h want %h", obs, want); end
      step();
      want = ev(1, 2'b01, 8'b0000_0100, 8'h5A, 0, 0);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL rs_inv2: got %h want %h", obs, want); end
      step();
      want = ev(1, 2'b11, 8'b0000_0010, 8'h5A, 0, 0);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL rs_reply: got %h want %h", obs, want); end
      step();
      want = ev(0, 2'b00, 8'h00, 8'h00, 1, 1);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL rs_done: got %h want %h", obs, want); end
      step();
   endtask

   task automatic test_null_owner();
      logic [20:0] want;
      mif.msg_ready = 1'b1;
      issue(1, 0, 1, 8'b0000_1000, 8'b0000_0000, 8'h99);
      want = ev(1, 2'b11, 8'b0000_1000, 8'h99, 0, 0);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL nullown_reply: got %h want %h", obs, want); end
      step();
      want = ev(0, 2'b00, 8'h00, 8'h00, 1, 1);
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL nullown_done: got %h want %h", obs, want); end
      step();
   endtask

   initial begin
      reset                 = 1'b1;
      req_valid             = 1'b0;
      send_fetch            = 1'b0;
      send_invalidate       = 1'b0;
      send_data_value_reply = 1'b0;
      requesting_processor  = '0;
      bit_vector            = '0;
      block_address         = '0;
      mif.msg_ready         = 1'b0;

      test_reset();
      test_shared_write_miss();
      test_exclusive_write_miss();
      test_fetch_only();
      test_backpressure();
      test_no_flags();
      test_reset_mid();
      test_requester_sharer();
      test_null_owner();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
